// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared definitions for the frequency meter.
//   state_t          - FSM state encoding (IDLE = 0, GATE = 1)
//   GATE_CYCLES_DEF  - default gate window length in fclk cycles
//   GATE_W           - width of the gate timer for the default window
package freq_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    localparam int unsigned GATE_CYCLES_DEF = 100000000;
    localparam int unsigned GATE_W          = $clog2(GATE_CYCLES_DEF);

endpackage

// File: rtl/freq_meter_sync_edge.sv
// sync_edge: 2-FF synchronizer followed by a registered rising-edge detect.
//   fclk     - system clock
//   reset    - synchronous active-high reset (clears all stages)
//   async_in - asynchronous input
//   rise     - one-cycle pulse per 0->1 of the synchronized input,
//              3 fclk cycles after the input transition
module sync_edge (
    input  logic fclk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic s2_d;

    always_ff @(posedge fclk) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= async_in;
            s2   <= s1;
            s2_d <= s2;
            rise <= s2 & ~s2_d;
        end
    end

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a gate
// window of GATE_CYCLES fclk cycles and reports the count once per window.
//   fclk       - system clock
//   reset      - synchronous active-high reset
//   enable     - level; high measures continuously, low idles
//   sig_in     - asynchronous signal to measure
//   edge_count - saturating edge count of the last completed window
//   overflow   - last completed window saturated
//   valid      - one-cycle pulse when edge_count/overflow update
//   busy       - a window is in progress
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int unsigned EDGE_W      = 16
) (
    input  logic              fclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sig_in,
    output logic [EDGE_W-1:0] edge_count,
    output logic              overflow,
    output logic              valid,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(GATE_CYCLES);

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   gate_cnt;
    logic [EDGE_W-1:0]  acc;
    logic               ovf_acc;
    logic               rise;

    logic               terminal;
    logic               acc_sat;
    logic               sat_hit;
    logic [EDGE_W-1:0]  acc_inc;

    sync_edge u_sync_edge (
        .fclk     (fclk),
        .reset    (reset),
        .async_in (sig_in),
        .rise     (rise)
    );

    assign terminal = (state == GATE) && (gate_cnt == CNT_W'(GATE_CYCLES - 1));
    assign acc_sat  = &acc;
    assign sat_hit  = rise & acc_sat;

    always_comb begin
        acc_inc = acc;
        if (rise && !acc_sat) begin
            acc_inc = acc + EDGE_W'(1);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = GATE;
                end
            end
            GATE: begin
                // the terminal cycle always completes, even with enable low
                if (terminal) begin
                    state_n = enable ? GATE : IDLE;
                end else if (!enable) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge fclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    assign busy = (state == GATE);

    always_ff @(posedge fclk) begin
        if (reset) begin
            gate_cnt   <= '0;
            acc        <= '0;
            ovf_acc    <= 1'b0;
            edge_count <= '0;
            overflow   <= 1'b0;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == GATE && terminal) begin
                // this cycle's rise is folded into the closing result
                edge_count <= acc_inc;
                overflow   <= ovf_acc | sat_hit;
                valid      <= 1'b1;
                gate_cnt   <= '0;
                acc        <= '0;
                ovf_acc    <= 1'b0;
            end else if (state == GATE && enable) begin
                gate_cnt <= gate_cnt + CNT_W'(1);
                acc      <= acc_inc;
                ovf_acc  <= ovf_acc | sat_hit;
            end else begin
                // idle or aborted window
                gate_cnt <= '0;
                acc      <= '0;
                ovf_acc  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Frequency meter for the Basys3 counter design. It counts rising edges of an asynchronous input `sig_in` over a fixed gate window of `fclk` cycles and reports the edge count once per window. It is the measuring end of the selectable-rate counter chain: a divided clock such as `clk_out`, `clk_out2`, `clk_out3` or `clk_out4` is fed in to confirm its rate. Its result drives the LEDs or seven-segment display.

## Interface
- `GATE_CYCLES`, default 100000000: gate window length in `fclk` cycles (1 s at 100 MHz). Must be ≥ 2.
- `EDGE_W`, default 16: width of the edge counter and the result.
- `fclk` in 1: system clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: level. High means measure continuously; low means idle.
- `sig_in` in 1: asynchronous signal to be measured.
- `edge_count` out EDGE_W: result of the last completed window. Saturating.
- `overflow` out 1: the last completed window saturated.
- `valid` out 1: one-cycle pulse when `edge_count` and `overflow` are updated.
- `busy` out 1: high while a window is in progress.

## Operation
- Input stage: `sig_in` passes through a 2-FF synchronizer, then a registered rising-edge detect. `rise` is high for one cycle for each 0→1 transition of the synchronized signal.
- Guaranteed counting requires `sig_in` high ≥ 2 and low ≥ 2 `fclk` cycles. Shorter pulses may be missed.
- State machine has two states, IDLE and GATE.
  - IDLE: `gate_cnt` = 0 and `acc` = 0. If `enable` = 1, go to GATE next cycle.
  - GATE:
    - `gate_cnt` counts 0 to GATE_CYCLES-1.
    - Each cycle with `rise` = 1 increments `acc`, saturating at 2^EDGE_W-1. Any increment attempted at saturation sets `ovf_acc`.
  - GATE, terminal cycle (`gate_cnt` = GATE_CYCLES-1):
    - `edge_count` <= `acc` plus this cycle's `rise`, saturated.
    - `overflow` <= `ovf_acc` OR (saturation this cycle).
    - `valid` <= 1.
    - `acc`, `ovf_acc` and `gate_cnt` are cleared.
    - Next state is GATE if `enable` = 1, otherwise IDLE.
- Back-to-back windows have no gap cycle, so no edge is lost between windows.
- `enable` falling in a non-terminal GATE cycle aborts the window:
  - next state is IDLE;
  - no `valid`;
  - `edge_count` and `overflow` hold the previous result.
- `enable` low in the terminal cycle still completes that window.
- `reset` overrides everything in the same cycle.
- `busy` = (state == GATE), registered.

## Timing
- Reset values: `edge_count` = 0, `overflow` = 0, `valid` = 0, `busy` = 0. State is IDLE, counters are 0, and both synchronizer FFs are 0.
- `enable` sampled high in cycle N gives `busy` = 1 from cycle N+1; window cycle 0 is cycle N+1.
- `valid` is high exactly in the cycle after the terminal cycle. That is cycle N+1+GATE_CYCLES for the first window, then every GATE_CYCLES cycles after.
- `edge_count` changes only in the same cycle as `valid`.
- Latency from a `sig_in` 0→1 transition to the `rise` pulse is 3 `fclk` cycles (2 synchronizer stages plus edge register). The edge is credited to whichever window contains the `rise` cycle.
- `rise` in the terminal cycle is counted in the closing window and never in the next one.
- Reset asserted mid-window: outputs are at reset values in the next cycle, with no `valid`. Measuring restarts only through IDLE→GATE.

## Structure
- Shared package (`freq_meter_pkg`):
  - state encoding: IDLE = 1'b0, GATE = 1'b1;
  - default `GATE_CYCLES`;
  - helper constant `GATE_W` = clog2(GATE_CYCLES) for `gate_cnt`.
- Sub-module `sync_edge`: 2-FF synchronizer plus registered rising-edge detect. Ports are `fclk`, `reset`, `async_in` and `rise`. It can be reused for the push-button paths.
- The top level holds the FSM, gate timer, saturating accumulator and output registers.

## Test plan
Use GATE_CYCLES = 20 and EDGE_W = 4 unless noted.
- Reset: hold `reset` 3 cycles with `sig_in` toggling → all outputs 0, with no `valid` while reset is high.
- `sig_in` = 0 constant, `enable` = 1 → `valid` every 20 cycles, `edge_count` = 0, `overflow` = 0.
- `sig_in` square wave, period 4 (2 high / 2 low), any phase, `enable` = 1 → every window reports `edge_count` = 5, with `valid` spaced exactly 20 cycles apart.
- Same stimulus with EDGE_W = 2 → `edge_count` = 3 and `overflow` = 1 each window.
- Period-4 input, `enable` dropped at window cycle 10 → no `valid`, `edge_count` holds 5, `busy` = 0 next cycle. Re-enable → next `valid` 20 cycles after the restart, value 5.
- `reset` pulsed at window cycle 12 of the second window → outputs 0 next cycle. With `enable` still high, a fresh window starts and reports 5.
